// File: rtl/conv_out_collector_pkg.sv
// Shared constants and FSM encoding for the convolution output collector.
package conv_out_collector_pkg;

  // Default partial-sum width (signed) and buffer depth (26x26 map).
  localparam int DEF_PW    = 8;
  localparam int DEF_DEPTH = 676;

  // Pixel counter / raster address width.
  localparam int PIX_W = 10;

  // Output map pixel counts per layer select.
  localparam logic [PIX_W-1:0] MAP_PIX_L0 = 10'd676;  // 26x26
  localparam logic [PIX_W-1:0] MAP_PIX_L1 = 10'd576;  // 24x24

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACC   = 2'd1,
    ST_FLUSH = 2'd2
  } fsm_e;

  // Expected pixels per pass for a given layer select.
  function automatic logic [PIX_W-1:0] map_pixels(input logic layer);
    return layer ? MAP_PIX_L1 : MAP_PIX_L0;
  endfunction

endpackage

// File: rtl/conv_out_collector_psum_ram.sv
// Partial-sum buffer: combinational read port, synchronous write port.
// Contents are deliberately not reset; pass 0 always overwrites.
module psum_ram #(
  parameter int PW    = 8,
  parameter int DEPTH = 676,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic [AW-1:0] rd_addr,
  output logic [PW-1:0] rd_data,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [PW-1:0] wr_data
);

  logic [PW-1:0] mem_q [DEPTH];

  // Asynchronous read of the current pixel's partial sum.
  assign rd_data = mem_q[rd_addr];

  // Write back the saturated accumulation.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

endmodule

// File: rtl/conv_out_collector.sv
// Collects per-channel convolution results into a saturating partial-sum
// buffer and, on the final channel pass, emits binarized activations.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for the first ivalid of a pass; pass flags live
// ST_ACC   | accumulating pixels with the flags latched at pass start
// ST_FLUSH | one cycle: pixel-count check, frame_done, pixel counter clear
module conv_out_collector
  import conv_out_collector_pkg::*;
#(
  parameter int PW    = DEF_PW,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 state,
  input  logic                 pass_first,
  input  logic                 pass_last,
  input  logic [4:0]           din,
  input  logic                 ivalid,
  input  logic                 idone,
  input  logic signed [PW-1:0] thresh,
  output logic                 bout,
  output logic                 bvalid,
  output logic [PIX_W-1:0]     baddr,
  output logic                 frame_done,
  output logic                 busy,
  output logic                 err
);

  fsm_e             fsm_q;
  logic [PIX_W-1:0] pix_q;
  logic [PIX_W-1:0] expect_q;
  logic             first_q;
  logic             last_q;
  logic             bout_q;
  logic             bvalid_q;
  logic [PIX_W-1:0] baddr_q;
  logic             frame_done_q;
  logic             err_q;

  logic             first_d;
  logic             last_d;
  logic [PIX_W-1:0] expect_d;
  logic             room;
  logic             accept;
  logic             overrun;
  logic [PW-1:0]    rd_data;
  logic signed [PW:0]   base_ext;
  logic signed [PW:0]   din_ext;
  logic signed [PW:0]   sum;
  logic signed [PW-1:0] acc_d;
  logic             bout_d;

  psum_ram #(
    .PW   (PW),
    .DEPTH(DEPTH),
    .AW   (PIX_W)
  ) u_psum_ram (
    .clk    (clk),
    .rd_addr(pix_q),
    .rd_data(rd_data),
    .we     (accept),
    .wr_addr(pix_q),
    .wr_data(acc_d)
  );

  // Pass flags: live inputs on the opening pixel, latched copies afterwards.
  always_comb begin
    first_d  = first_q;
    last_d   = last_q;
    expect_d = expect_q;
    if (fsm_q == ST_IDLE) begin
      first_d  = pass_first;
      last_d   = pass_last;
      expect_d = map_pixels(state);
    end
  end

  assign room    = (pix_q < expect_d);
  assign accept  = ivalid && ((fsm_q == ST_IDLE) || (fsm_q == ST_ACC)) && room;
  assign overrun = ivalid && (fsm_q == ST_ACC) && !room;

  // Accumulate one extra bit wide, then clamp back to PW bits.
  always_comb begin
    base_ext = first_d ? '0 : {rd_data[PW-1], rd_data};
    din_ext  = {{(PW-4){din[4]}}, din};
    sum      = base_ext + din_ext;
    if (sum[PW] != sum[PW-1]) begin
      acc_d = sum[PW] ? {1'b1, {(PW-1){1'b0}}} : {1'b0, {(PW-1){1'b1}}};
    end else begin
      acc_d = sum[PW-1:0];
    end
    bout_d = (acc_d >= thresh);
  end

  // Pass sequencing, pixel counting and registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fsm_q        <= ST_IDLE;
      pix_q        <= '0;
      expect_q     <= MAP_PIX_L0;
      first_q      <= 1'b0;
      last_q       <= 1'b0;
      bout_q       <= 1'b0;
      bvalid_q     <= 1'b0;
      baddr_q      <= '0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      bvalid_q     <= 1'b0;
      frame_done_q <= 1'b0;

      if (accept) begin
        pix_q <= pix_q + 10'd1;
        if (last_d) begin
          bvalid_q <= 1'b1;
          bout_q   <= bout_d;
          baddr_q  <= pix_q;
        end
      end

      if (overrun) begin
        err_q <= 1'b1;
      end

      case (fsm_q)
        ST_IDLE: begin
          if (ivalid) begin
            fsm_q    <= ST_ACC;
            first_q  <= pass_first;
            last_q   <= pass_last;
            expect_q <= map_pixels(state);
          end
        end
        ST_ACC: begin
          if (idone) begin
            fsm_q        <= ST_FLUSH;
            frame_done_q <= last_q;
          end
        end
        ST_FLUSH: begin
          if (pix_q != expect_q) begin
            err_q <= 1'b1;
          end
          pix_q <= '0;
          fsm_q <= ST_IDLE;
        end
        default: fsm_q <= ST_IDLE;
      endcase
    end
  end

  assign bout       = bout_q;
  assign bvalid     = bvalid_q;
  assign baddr      = baddr_q;
  assign frame_done = frame_done_q;
  assign busy       = (fsm_q != ST_IDLE);
  assign err        = err_q;

endmodule

// File: tb/tb_conv_out_collector.sv
// Directed, table-driven bench for conv_out_collector.
module tb_conv_out_collector;

  logic              clk = 1'b0;
  logic              rstn;
  logic              state;
  logic              pass_first;
  logic              pass_last;
  logic [4:0]        din;
  logic              ivalid;
  logic              idone;
  logic signed [7:0] thresh;
  logic              bout;
  logic              bvalid;
  logic [9:0]        baddr;
  logic              frame_done;
  logic              busy;
  logic              err;

  int n_chk = 0;
  int n_err = 0;

  conv_out_collector dut (
    .clk       (clk),
    .rstn      (rstn),
    .state     (state),
    .pass_first(pass_first),
    .pass_last (pass_last),
    .din       (din),
    .ivalid    (ivalid),
    .idone     (idone),
    .thresh    (thresh),
    .bout      (bout),
    .bvalid    (bvalid),
    .baddr     (baddr),
    .frame_done(frame_done),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit st;
    bit f_first;
    bit f_last;
    int dinv;
    int thr;
    int npix;
    bit coinc;    // idone on the same cycle as the last pixel
    int flip;     // pixel index at which pass inputs are toggled, -1 = never
    bit e_bout;
    int e_nbv;
    int e_fd;
    bit e_err;
  } vec_t;

  vec_t tbl[20];

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run_pass(input vec_t v, input string tag);
    int nbv = 0, bad_addr = 0, bad_bout = 0, nfd = 0;
    int cyc = 0, lastbv = -1, fdc = -1, busy_mid = 0;
    state      = v.st;
    pass_first = v.f_first;
    pass_last  = v.f_last;
    thresh     = 8'(v.thr);
    din        = 5'(v.dinv);
    for (int it = 0; it < v.npix + 4; it++) begin
      if (it < v.npix) begin
        if (it == v.flip) begin
          state      = ~state;
          pass_first = ~pass_first;
          pass_last  = ~pass_last;
        end
        ivalid = 1'b1;
        idone  = v.coinc && (it == v.npix - 1);
      end else begin
        ivalid = 1'b0;
        idone  = !v.coinc && (it == v.npix);
      end
      @(posedge clk);
      #1;
      cyc++;
      if (it == 0) busy_mid = busy;
      if (bvalid) begin
        if (baddr != 10'(nbv)) bad_addr++;
        if (bout != v.e_bout) bad_bout++;
        nbv++;
        lastbv = cyc;
      end
      if (frame_done) begin
        nfd++;
        fdc = cyc;
      end
    end
    idone = 1'b0;
    check({tag, ".busy_mid"}, busy_mid, 1);
    check({tag, ".nbvalid"}, nbv, v.e_nbv);
    check({tag, ".baddr_bad"}, bad_addr, 0);
    check({tag, ".bout_bad"}, bad_bout, 0);
    check({tag, ".frame_done"}, nfd, v.e_fd);
    check({tag, ".err"}, err, v.e_err);
    check({tag, ".busy_end"}, busy, 0);
    if (v.e_fd == 1 && !v.coinc && !v.e_err)
      check({tag, ".fd_after_last_bvalid"}, fdc, lastbv + 1);
  endtask

  task automatic pulse_reset();
    rstn = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  initial begin
    vec_t v;
    int nbv, nfd, nbusy;

    rstn = 1'b0; state = 1'b0; pass_first = 1'b0; pass_last = 1'b0;
    din = '0; ivalid = 1'b0; idone = 1'b0; thresh = '0;

    // 26x26 single pass, +3 each, thresh 2 -> all ones
    tbl[0] = '{0, 1, 1,  3,   2, 676, 0,  -1, 1, 676, 1, 0};
    // 24x24 two passes: -5 then +4 -> -1 < 0; mid-pass input toggles ignored
    tbl[1] = '{1, 1, 0, -5,   0, 576, 0,  -1, 0,   0, 0, 0};
    tbl[2] = '{1, 0, 1,  4,   0, 576, 1, 100, 0, 576, 1, 0};
    // 15 passes of +9: 135 saturates to 127, 127 >= 127
    for (int p = 0; p < 15; p++)
      tbl[3+p] = '{0, p == 0, p == 14, 9, 127, 676, 0, -1, 1,
                   (p == 14) ? 676 : 0, (p == 14) ? 1 : 0, 0};
    // threshold equality boundary on a negative sum
    tbl[18] = '{1, 1, 1, -9, -9, 576, 0, -1, 1, 576, 1, 0};
    tbl[19] = '{1, 1, 1, -9, -8, 576, 1, -1, 0, 576, 1, 0};

    repeat (2) @(posedge clk);
    #1;
    check("rst.bvalid", bvalid, 0);
    check("rst.bout", bout, 0);
    check("rst.baddr", baddr, 0);
    check("rst.frame_done", frame_done, 0);
    check("rst.busy", busy, 0);
    check("rst.err", err, 0);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    for (int k = 0; k < 20; k++)
      run_pass(tbl[k], $sformatf("vec%0d", k));

    // idone in IDLE is ignored
    idone = 1'b1;
    @(posedge clk);
    #1;
    idone = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("idle_idone.busy", busy, 0);
    check("idle_idone.err", err, 0);

    // short pass: 675 of 676 pixels
    v = '{0, 1, 0, 1, 0, 675, 0, -1, 0, 0, 0, 1};
    run_pass(v, "short");

    pulse_reset();
    check("after_rst.err", err, 0);

    // overrun: 577 pixels on a 24x24 last pass, the extra one dropped
    v = '{1, 1, 1, 2, 0, 577, 0, -1, 1, 576, 1, 1};
    run_pass(v, "overrun");

    pulse_reset();

    // reset at pixel 300 of a last pass
    state = 1'b0; pass_first = 1'b1; pass_last = 1'b1; thresh = '0; din = 5'd1;
    nbv = 0;
    for (int i = 0; i < 300; i++) begin
      ivalid = 1'b1;
      @(posedge clk);
      #1;
      if (bvalid) nbv++;
    end
    check("midrst.nbv_before", nbv, 300);
    check("midrst.busy_before", busy, 1);
    rstn = 1'b0;
    #1;
    check("midrst.bvalid", bvalid, 0);
    check("midrst.busy", busy, 0);
    check("midrst.err", err, 0);
    nbv = 0; nfd = 0; nbusy = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      if (bvalid) nbv++;
      if (frame_done) nfd++;
      if (busy) nbusy++;
    end
    ivalid = 1'b0;
    rstn = 1'b1;
    idone = 1'b1;
    @(posedge clk);
    #1;
    idone = 1'b0;
    if (bvalid) nbv++;
    if (frame_done) nfd++;
    if (busy) nbusy++;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      if (bvalid) nbv++;
      if (frame_done) nfd++;
      if (busy) nbusy++;
    end
    check("midrst.bvalid_after", nbv, 0);
    check("midrst.frame_done_after", nfd, 0);
    check("midrst.busy_after", nbusy, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
